// File: rtl/vctr_op_strm.sv
// Element-wise operator between two streamed vectors.
// Two input FIFOs are popped in pairs into a two-stage pipeline. The pipeline applies
// ADD, SUB, ABS_DIFF or SQR_DIFF and writes the results into an output FIFO.
// Pair pops are credit-gated so that the output FIFO can never overflow.

// Circular FIFO with a registered read port. The storage array carries no reset.
module vctr_op_strm_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [W-1:0]  rd_data_reg;
  logic          do_wr, do_rd;

  assign do_wr   = wr_en && (count_reg != CW'(DEPTH));
  assign do_rd   = rd_en && (count_reg != '0);
  assign count   = count_reg;
  assign rd_data = rd_data_reg;

  // Storage write; no reset so that the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers, occupancy and the read register. The read register holds its value when no pop occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      if (do_rd) begin
        rd_ptr_reg  <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
        rd_data_reg <= mem[rd_ptr_reg];
      end
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

module vctr_op_strm #(
  parameter int DATA_WIDTH    = 16,
  parameter int LENGTH_BITS   = 10,
  parameter int BUFFER_LENGTH = 4,
  parameter int SIGNED_IN     = 0
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_in_v1_en,
  input  logic [DATA_WIDTH-1:0]    data_in_v1,
  output logic                     data_in_v1_full,
  input  logic                     data_in_v2_en,
  input  logic [DATA_WIDTH-1:0]    data_in_v2,
  output logic                     data_in_v2_full,
  input  logic                     data_out_en,
  output logic [2*DATA_WIDTH-1:0]  data_out,
  output logic                     data_out_empty,
  input  logic [LENGTH_BITS-1:0]   vector_length,
  input  logic [1:0]               op_mode,
  input  logic                     start,
  output logic                     done,
  output logic                     idle,
  output logic                     ready
);
  localparam int   OUT_WIDTH = 2 * DATA_WIDTH;
  localparam int   EXT_W     = DATA_WIDTH + 1;
  localparam int   PAD_W     = OUT_WIDTH - EXT_W;
  localparam int   CW        = $clog2(BUFFER_LENGTH + 1);
  localparam logic SGN       = (SIGNED_IN != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_COMPUTE, ST_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [LENGTH_BITS-1:0]  len_reg, rd_cnt_reg, wr_cnt_reg;
  logic [1:0]              mode_reg;
  logic                    s1_valid_reg, s2_valid_reg;
  logic [OUT_WIDTH-1:0]    s2_result_reg, result;
  logic                    start_take, pair_pop, out_pop;
  logic [1:0]              in_en, can_take, in_empty;
  logic [DATA_WIDTH-1:0]   in_data [2];
  logic [DATA_WIDTH-1:0]   operand [2];
  logic [CW-1:0]           out_count;
  logic [CW:0]             occupancy;

  assign in_en      = {data_in_v2_en, data_in_v1_en};
  assign in_data[0] = data_in_v1;
  assign in_data[1] = data_in_v2;
  assign data_in_v1_full = !can_take[0];
  assign data_in_v2_full = !can_take[1];

  assign start_take = (state_reg == ST_IDLE) && start;

  // Each input channel has its own FIFO and acceptance counter; the channels are not coupled to each other.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_in
      logic [CW-1:0]          in_count;
      logic [LENGTH_BITS-1:0] acc_reg;
      logic                   accept;

      assign can_take[gi] = (state_reg == ST_COMPUTE) && (in_count != CW'(BUFFER_LENGTH)) &&
                            (acc_reg < len_reg);
      assign accept       = in_en[gi] && can_take[gi];
      assign in_empty[gi] = (in_count == '0);

      vctr_op_strm_fifo #(.W(DATA_WIDTH), .DEPTH(BUFFER_LENGTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data (in_data[gi]),
        .rd_en   (pair_pop),
        .rd_data (operand[gi]),
        .count   (in_count)
      );

      // Count accepted writes. Once len elements have been accepted, further writes are refused.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          acc_reg <= '0;
        else if (start_take) acc_reg <= '0;
        else if (accept)     acc_reg <= acc_reg + LENGTH_BITS'(1);
      end
    end
  endgenerate

  // Credits: results already in the output FIFO plus results still in the pipeline.
  assign occupancy = {1'b0, out_count} + {{CW{1'b0}}, s1_valid_reg} + {{CW{1'b0}}, s2_valid_reg};
  assign pair_pop  = (state_reg == ST_COMPUTE) && !in_empty[0] && !in_empty[1] &&
                     (rd_cnt_reg < len_reg) && (occupancy < (CW + 1)'(BUFFER_LENGTH));
  assign out_pop   = data_out_en && (state_reg != ST_IDLE);

  // Combinational operator on the stage-1 operands (the FIFO read registers).
  always_comb begin
    logic [EXT_W-1:0]     a_ext, b_ext, sum_ext, diff_ext, abs_ext;
    logic [OUT_WIDTH-1:0] abs_wide;
    a_ext    = SGN ? {operand[0][DATA_WIDTH-1], operand[0]} : {1'b0, operand[0]};
    b_ext    = SGN ? {operand[1][DATA_WIDTH-1], operand[1]} : {1'b0, operand[1]};
    sum_ext  = a_ext + b_ext;
    diff_ext = a_ext - b_ext;
    abs_ext  = diff_ext[EXT_W-1] ? (~diff_ext + EXT_W'(1)) : diff_ext;
    abs_wide = {{PAD_W{1'b0}}, abs_ext};
    result   = {{PAD_W{SGN & sum_ext[EXT_W-1]}}, sum_ext};
    case (mode_reg)
      2'b01:   result = {{PAD_W{diff_ext[EXT_W-1]}}, diff_ext};
      2'b10:   result = abs_wide;
      2'b11:   result = abs_wide * abs_wide;
      default: result = {{PAD_W{SGN & sum_ext[EXT_W-1]}}, sum_ext};
    endcase
  end

  // FSM state, per-vector configuration, counters and the pipeline valid/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      mode_reg      <= '0;
      rd_cnt_reg    <= '0;
      wr_cnt_reg    <= '0;
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s2_result_reg <= '0;
    end else begin
      state_reg    <= state_next;
      s1_valid_reg <= pair_pop;
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) s2_result_reg <= result;
      if (start_take) begin
        len_reg    <= vector_length;
        mode_reg   <= op_mode;
        rd_cnt_reg <= '0;
        wr_cnt_reg <= '0;
      end else begin
        if (pair_pop)     rd_cnt_reg <= rd_cnt_reg + LENGTH_BITS'(1);
        if (s2_valid_reg) wr_cnt_reg <= wr_cnt_reg + LENGTH_BITS'(1);
      end
    end
  end

  // Next-state logic and state flags.
  always_comb begin
    state_next = state_reg;
    idle       = 1'b0;
    ready      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        idle = 1'b1;
        if (start) state_next = (vector_length == '0) ? ST_DONE : ST_COMPUTE;
      end
      ST_COMPUTE: begin
        ready = 1'b1;
        if (wr_cnt_reg == len_reg) state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (data_out_empty) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  vctr_op_strm_fifo #(.W(OUT_WIDTH), .DEPTH(BUFFER_LENGTH)) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (s2_valid_reg),
    .wr_data (s2_result_reg),
    .rd_en   (out_pop),
    .rd_data (data_out),
    .count   (out_count)
  );

  assign data_out_empty = (out_count == '0);
endmodule

// File: tb/tb_vctr_op_strm.sv
// Testbench for vctr_op_strm. It drives an unsigned instance and a signed instance with
// identical stimulus. Each result is checked against an arithmetic reference that works on integers.
`timescale 1ns/1ps
module tb_vctr_op_strm;
  localparam int DW = 16;
  localparam int LB = 10;
  localparam int OW = 2 * DW;
  localparam int STALL = 40;

  logic          clk, rst_n;
  logic          v1_en, v2_en, dout_en, start;
  logic [DW-1:0] v1, v2;
  logic [LB-1:0] vector_length;
  logic [1:0]    op_mode;
  logic          full1_u, full2_u, empty_u, done_u, idle_u, ready_u;
  logic          full1_s, full2_s, empty_s, done_s, idle_s, ready_s;
  logic [OW-1:0] dout_u, dout_s;
  logic [DW-1:0] tv1[$], tv2[$];
  int            n_cmp = 0, n_bad = 0;

  vctr_op_strm #(.DATA_WIDTH(DW), .LENGTH_BITS(LB), .BUFFER_LENGTH(4), .SIGNED_IN(0)) dut_u (
    .clk(clk), .rst_n(rst_n),
    .data_in_v1_en(v1_en), .data_in_v1(v1), .data_in_v1_full(full1_u),
    .data_in_v2_en(v2_en), .data_in_v2(v2), .data_in_v2_full(full2_u),
    .data_out_en(dout_en), .data_out(dout_u), .data_out_empty(empty_u),
    .vector_length(vector_length), .op_mode(op_mode), .start(start),
    .done(done_u), .idle(idle_u), .ready(ready_u)
  );

  vctr_op_strm #(.DATA_WIDTH(DW), .LENGTH_BITS(LB), .BUFFER_LENGTH(4), .SIGNED_IN(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .data_in_v1_en(v1_en), .data_in_v1(v1), .data_in_v1_full(full1_s),
    .data_in_v2_en(v2_en), .data_in_v2(v2), .data_in_v2_full(full2_s),
    .data_out_en(dout_en), .data_out(dout_s), .data_out_empty(empty_s),
    .vector_length(vector_length), .op_mode(op_mode), .start(start),
    .done(done_s), .idle(idle_s), .ready(ready_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required $finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer arithmetic on the operands as interpreted (signed or unsigned), truncated to OW bits.
  function automatic logic [OW-1:0] ref_op(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                           input logic [1:0] m, input bit sgn);
    longint a, b, d, r;
    a = sgn ? longint'($signed(x)) : longint'(x);
    b = sgn ? longint'($signed(y)) : longint'(y);
    d = a - b;
    case (m)
      2'd0:    r = a + b;
      2'd1:    r = d;
      2'd2:    r = (d < 0) ? -d : d;
      default: r = d * d;
    endcase
    return r[OW-1:0];
  endfunction

  task automatic fill(input int n);
    tv1.delete();
    tv2.delete();
    for (int k = 0; k < n; k++) begin
      tv1.push_back(DW'($urandom));
      tv2.push_back(DW'($urandom));
    end
  endtask

  // Run one vector. lag delays channel 2. extra adds writes on v1 beyond len, which must be refused.
  // stall suppresses output pops for STALL cycles. abort_at returns once that many results have been read.
  task automatic run_vec(input int len, input logic [1:0] mode, input int lag, input int extra,
                         input bit stall, input int abort_at);
    logic [OW-1:0] eu[$], es[$];
    int i1, i2, ex, nres, cyc, first_wr, first_ne, budget;
    bit saw_done, fin, pop, acc1, acc2;
    i1 = 0; i2 = 0; ex = 0; nres = 0; cyc = 0; first_wr = -1; first_ne = -1;
    saw_done = 0; fin = 0;
    for (int k = 0; k < len; k++) begin
      eu.push_back(ref_op(tv1[k], tv2[k], mode, 1'b0));
      es.push_back(ref_op(tv1[k], tv2[k], mode, 1'b1));
    end
    budget = 3 * len + 80;
    check("idle_before_start", idle_u, 1);
    op_mode = mode; vector_length = LB'(len); start = 1'b1;
    step();
    start = 1'b0;
    if (len == 0) begin
      check("zero_len_done_u", done_u, 1);
      check("zero_len_done_s", done_s, 1);
      check("zero_len_empty", empty_u, 1);
      step();
      check("zero_len_idle_u", idle_u, 1);
      check("zero_len_idle_s", idle_s, 1);
      return;
    end
    check("ready_after_start_u", ready_u, 1);
    check("ready_after_start_s", ready_s, 1);
    check("no_done_after_start", done_u, 0);
    while (cyc < budget) begin
      if (stall && cyc == STALL - 1) begin
        check("stall_v1_all_taken", i1, len);
        check("stall_v2_all_taken", i2, len);
        check("stall_not_done", done_u, 0);
        check("stall_still_ready", ready_u, 1);
        check("stall_out_nonempty", empty_u, 0);
      end
      start = (cyc == 3);
      vector_length = LB'($urandom);
      op_mode = 2'($urandom);
      v1_en = 1'b0; v2_en = 1'b0;
      if (i1 < len) begin
        v1_en = 1'b1; v1 = tv1[i1];
      end else if (ex < extra) begin
        v1_en = 1'b1; v1 = DW'($urandom);
        check("v1_full_reject_u", full1_u, 1);
        check("v1_full_reject_s", full1_s, 1);
        ex++;
      end
      if (cyc >= lag && i2 < len) begin
        v2_en = 1'b1; v2 = tv2[i2];
      end
      acc1 = v1_en && (i1 < len) && !full1_u;
      acc2 = v2_en && !full2_u;
      if (first_wr < 0 && acc1 && acc2 && i1 == 0 && i2 == 0) first_wr = cyc;
      pop = (!stall || cyc >= STALL) && !empty_u;
      dout_en = pop;
      step();
      cyc++;
      if (acc1) i1++;
      if (acc2) i2++;
      if (pop) begin
        if (nres < len) begin
          check("data_u", dout_u, eu[nres]);
          check("data_s", dout_s, es[nres]);
        end else begin
          check("no_extra_result", nres + 1, len);
        end
        nres++;
      end
      if (first_ne < 0 && !empty_u) first_ne = cyc;
      if (done_u) saw_done = 1;
      if (abort_at > 0 && nres == abort_at) return;
      if (idle_u && nres == len) begin
        fin = 1;
        break;
      end
    end
    dout_en = 1'b0; v1_en = 1'b0; v2_en = 1'b0; start = 1'b0;
    check("finished_in_budget", fin, 1);
    check("saw_done", saw_done, 1);
    check("result_count", nres, len);
    check("empty_at_end_u", empty_u, 1);
    check("empty_at_end_s", empty_s, 1);
    if (lag == 0 && !stall) check("first_result_latency", first_ne - first_wr, 4);
    $display("vector len=%0d mode=%0d lag=%0d stall=%0d results=%0d", len, mode, lag, stall, nres);
  endtask

  task automatic check_reset_state(input string ph);
    check({ph, "_idle_u"}, idle_u, 1);   check({ph, "_idle_s"}, idle_s, 1);
    check({ph, "_ready"}, ready_u, 0);   check({ph, "_done"}, done_u, 0);
    check({ph, "_empty_u"}, empty_u, 1); check({ph, "_empty_s"}, empty_s, 1);
    check({ph, "_full1"}, full1_u, 1);   check({ph, "_full2"}, full2_u, 1);
    check({ph, "_dout_u"}, dout_u, 0);   check({ph, "_dout_s"}, dout_s, 0);
  endtask

  initial begin
    rst_n = 1'b0; v1_en = 1'b0; v2_en = 1'b0; dout_en = 1'b0; start = 1'b0;
    v1 = '0; v2 = '0; vector_length = '0; op_mode = '0;
    repeat (3) step();
    check_reset_state("reset");
    rst_n = 1'b1;
    step();
    check_reset_state("post_reset");

    // ADD with known values.
    tv1 = '{16'd1, 16'd2, 16'd3, 16'd4};
    tv2 = '{16'd10, 16'd20, 16'd30, 16'd40};
    run_vec(4, 2'd0, 0, 0, 1'b0, 0);

    // SQR_DIFF at the extremes of the signed range.
    tv1 = '{16'h8000};
    tv2 = '{16'h7FFF};
    run_vec(1, 2'd3, 0, 0, 1'b0, 0);

    // ABS_DIFF and SUB with v1 < v2.
    tv1 = '{16'd3};
    tv2 = '{16'd5};
    run_vec(1, 2'd2, 0, 0, 1'b0, 0);
    run_vec(1, 2'd1, 0, 0, 1'b0, 0);

    // Output backpressure: no pops until the out FIFO and the input FIFOs are full.
    fill(8);
    run_vec(8, 2'($urandom), 0, 0, 1'b1, 0);

    // Over-length writes on v1, with v2 lagging.
    fill(3);
    run_vec(3, 2'($urandom), 4, 2, 1'b0, 0);

    // Zero-length vector.
    run_vec(0, 2'd0, 0, 0, 1'b0, 0);

    // Reset in the middle of a vector, then a fresh vector.
    fill(6);
    run_vec(6, 2'd0, 0, 0, 1'b0, 2);
    v1_en = 1'b0; v2_en = 1'b0; dout_en = 1'b0; start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_abort");
    step();
    rst_n = 1'b1;
    step();
    fill(2);
    run_vec(2, 2'($urandom), 0, 0, 1'b0, 0);

    // Randomised vectors.
    for (int r = 0; r < 8; r++) begin
      int rl;
      rl = $urandom_range(1, 12);
      fill(rl);
      run_vec(rl, 2'($urandom), $urandom_range(0, 5), 0, 1'b0, 0);
    end

    // Maximum length.
    fill(1023);
    run_vec(1023, 2'($urandom), 0, 0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
